// File: rtl/mbc6_pkg.sv
// Shared definitions for the MBC6 flash command sequencer: decoder state encoding, command
// bytes, unlock addresses and default ID bytes.
package mbc6_pkg;

  typedef enum logic [3:0] {
    StRead,
    StUnlock1,
    StUnlock2,
    StId,
    StProgArm,
    StEr1,
    StEr2,
    StEr3,
    StProgRd,
    StProgWr,
    StErase
  } flash_state_e;

  localparam logic [7:0] CmdUnlock1 = 8'hAA;
  localparam logic [7:0] CmdUnlock2 = 8'h55;
  localparam logic [7:0] CmdId      = 8'h90;
  localparam logic [7:0] CmdProg    = 8'hA0;
  localparam logic [7:0] CmdErase   = 8'h80;
  localparam logic [7:0] CmdSector  = 8'h30;
  localparam logic [7:0] CmdChip    = 8'h10;
  localparam logic [7:0] CmdReset   = 8'hF0;

  // Only the low 15 address bits take part in unlock decoding.
  localparam logic [14:0] UnlockAddr1 = 15'h5555;
  localparam logic [14:0] UnlockAddr2 = 15'h2AAA;

  localparam logic [7:0] MfrIdDefault = 8'hC2;
  localparam logic [7:0] DevIdDefault = 8'h81;

  function automatic logic is_busy_state(flash_state_e s);
    return (s == StProgRd) || (s == StProgWr) || (s == StErase);
  endfunction

endpackage

// File: rtl/mbc6_flash_ctrl_if.sv
// Backing-memory port shared with the SDRAM arbiter.
//   req    master->slave  request, held until ack
//   we     master->slave  1 = write, 0 = read
//   addr   master->slave  byte address
//   wdata  master->slave  write data
//   rdata  slave->master  read data, valid with ack
//   ack    slave->master  one-cycle completion pulse
interface mbc6_flash_ctrl_if #(
  parameter int unsigned ADDR_W = 20
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic [7:0]        rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mbc6_flash_mem_if.sv
// Request/acknowledge sequencer towards backing memory. Runs single reads/writes for program
// and walks an address counter writing FF for sector/chip erase.
//   clk_sys, reset          clock, synchronous active-high reset
//   start_rd/start_wr       issue one read/write at start_addr (only honoured when ready)
//   start_erase, erase_chip begin erase of start_addr's sector, or of the whole chip
//   start_addr, start_wdata command address / write data
//   ready                   no request outstanding and no erase in progress
//   done                    pulse: single access acked, or final erase write acked
//   rdata                   data captured from the last read ack
//   dirty                   sticky: any memory write completed since reset
//   mem                     backing-memory port
module mbc6_flash_mem_if #(
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned SECTOR_W = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start_rd,
  input  logic              start_wr,
  input  logic              start_erase,
  input  logic              erase_chip,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [7:0]        start_wdata,
  output logic              ready,
  output logic              done,
  output logic [7:0]        rdata,
  output logic              dirty,
  mbc6_flash_ctrl_if.master mem
);

  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              erasing_q, erasing_d;
  logic              chip_q, chip_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              dirty_q, dirty_d;

  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] sector_base;
  logic              wrap;
  logic              ack_seen;

  assign addr_inc = addr_q + 1'b1;
  // Erase ends when the counter would roll over the sector (or the whole array for chip).
  assign wrap     = chip_q ? (addr_inc == '0) : (addr_inc[SECTOR_W-1:0] == '0);
  assign ack_seen = req_q & mem.ack;
  assign ready    = ~req_q & ~erasing_q;
  assign done     = ack_seen & (~erasing_q | wrap);

  always_comb begin
    sector_base                 = start_addr;
    sector_base[SECTOR_W-1:0]   = '0;
  end

  always_comb begin
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    erasing_d = erasing_q;
    chip_d    = chip_q;
    rdata_d   = rdata_q;
    dirty_d   = dirty_q;
    if (ack_seen) begin
      req_d = 1'b0;
      if (we_q) begin
        dirty_d = 1'b1;
      end else begin
        rdata_d = mem.rdata;
      end
      if (erasing_q) begin
        if (wrap) begin
          erasing_d = 1'b0;
        end else begin
          addr_d = addr_inc;
        end
      end
    end else if (erasing_q && !req_q) begin
      // One idle cycle after each ack, then the next FF write.
      req_d = 1'b1;
    end else if (ready) begin
      if (start_rd) begin
        req_d   = 1'b1;
        we_d    = 1'b0;
        addr_d  = start_addr;
        wdata_d = 8'h00;
      end else if (start_wr) begin
        req_d   = 1'b1;
        we_d    = 1'b1;
        addr_d  = start_addr;
        wdata_d = start_wdata;
      end else if (start_erase) begin
        req_d     = 1'b1;
        we_d      = 1'b1;
        wdata_d   = 8'hFF;
        erasing_d = 1'b1;
        chip_d    = erase_chip;
        addr_d    = erase_chip ? '0 : sector_base;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 8'h00;
      erasing_q <= 1'b0;
      chip_q    <= 1'b0;
      rdata_q   <= 8'h00;
      dirty_q   <= 1'b0;
    end else begin
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      erasing_q <= erasing_d;
      chip_q    <= chip_d;
      rdata_q   <= rdata_d;
      dirty_q   <= dirty_d;
    end
  end

  assign mem.req   = req_q;
  assign mem.we    = we_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;
  assign rdata     = rdata_q;
  assign dirty     = dirty_q;

endmodule

// File: rtl/mbc6_flash_ctrl.sv
// Command sequencer for the MBC6 1MB flash. Decodes CPU unlock/command writes, runs program
// (read-modify-write, bits only clear) and sector/chip erase, and overrides CPU read data with
// ID bytes or busy-status bytes.
//   clk_sys, reset   clock, synchronous active-high reset
//   ce_cpu           CPU clock enable qualifying cpu_wr/cpu_rd
//   flash_en         flash mapped; 0 forces the decoder idle between commands
//   flash_we         flash write enable; 0 refuses program/erase
//   cpu_wr, cpu_rd   CPU write/read strobes to the flash window
//   cpu_addr, cpu_di CPU byte address and write data
//   cpu_do           override read data (registered)
//   cpu_do_ovr       select cpu_do instead of memory data
//   busy             program/erase in progress
//   dirty            some memory write has completed since reset
//   mem              backing-memory port
module mbc6_flash_ctrl
  import mbc6_pkg::*;
#(
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned SECTOR_W = 16,
  parameter logic [7:0]  MFR_ID   = MfrIdDefault,
  parameter logic [7:0]  DEV_ID   = DevIdDefault
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce_cpu,
  input  logic              flash_en,
  input  logic              flash_we,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_di,
  output logic [7:0]        cpu_do,
  output logic              cpu_do_ovr,
  output logic              busy,
  output logic              dirty,
  mbc6_flash_ctrl_if.master mem
);

  flash_state_e      state_q, state_d;
  logic [7:0]        data_q, data_d;
  logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
  logic [7:0]        cpu_do_q, cpu_do_d;
  logic              toggle_q, toggle_d;
  logic              busy_q;

  logic              wr, rd, at_unlock1, at_unlock2, busy_now, dq7;
  logic              start_rd, start_wr, start_erase, erase_chip;
  logic              mem_ready, mem_done, mem_dirty;
  logic [7:0]        mem_rdata;
  logic [ADDR_W-1:0] start_addr;

  assign wr         = ce_cpu & cpu_wr & flash_en;
  assign rd         = ce_cpu & cpu_rd;
  assign at_unlock1 = (cpu_addr[14:0] == UnlockAddr1);
  assign at_unlock2 = (cpu_addr[14:0] == UnlockAddr2);
  assign busy_now   = is_busy_state(state_q);
  assign dq7        = (state_q == StErase) ? 1'b0 : ~data_q[7];
  assign start_addr = (state_q == StProgWr) ? prog_addr_q : cpu_addr;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    prog_addr_d = prog_addr_q;
    start_rd    = 1'b0;
    start_wr    = 1'b0;
    start_erase = 1'b0;
    erase_chip  = 1'b0;
    case (state_q)
      StRead: begin
        if (wr && cpu_di == CmdUnlock1 && at_unlock1) state_d = StUnlock1;
      end
      StUnlock1: begin
        if (wr) state_d = (cpu_di == CmdUnlock2 && at_unlock2) ? StUnlock2 : StRead;
      end
      StUnlock2: begin
        if (wr) begin
          state_d = StRead;
          if (at_unlock1) begin
            case (cpu_di)
              CmdId:    state_d = StId;
              CmdProg:  if (flash_we) state_d = StProgArm;
              CmdErase: if (flash_we) state_d = StEr1;
              default:  state_d = StRead;
            endcase
          end
        end
      end
      StId: begin
        if (wr && cpu_di == CmdReset) state_d = StRead;
      end
      StProgArm: begin
        if (wr) begin
          if (cpu_di == CmdReset) begin
            state_d = StRead;
          end else begin
            data_d      = cpu_di;
            prog_addr_d = cpu_addr;
            start_rd    = 1'b1;
            state_d     = StProgRd;
          end
        end
      end
      StEr1: begin
        if (wr) state_d = (cpu_di == CmdUnlock1 && at_unlock1) ? StEr2 : StRead;
      end
      StEr2: begin
        if (wr) state_d = (cpu_di == CmdUnlock2 && at_unlock2) ? StEr3 : StRead;
      end
      StEr3: begin
        if (wr) begin
          state_d = StRead;
          if (cpu_di == CmdSector) begin
            start_erase = 1'b1;
            state_d     = StErase;
          end else if (cpu_di == CmdChip && at_unlock1) begin
            start_erase = 1'b1;
            erase_chip  = 1'b1;
            state_d     = StErase;
          end
        end
      end
      StProgRd: begin
        if (mem_done) state_d = StProgWr;
      end
      StProgWr: begin
        // The read's req drops first; issue the write once the sequencer is free.
        if (mem_ready) start_wr = 1'b1;
        if (mem_done) state_d = StRead;
      end
      StErase: begin
        if (mem_done) state_d = StRead;
      end
      default: state_d = StRead;
    endcase
    // A disabled window abandons any half-entered command, but never an operation in flight.
    if (!flash_en && !busy_now) state_d = StRead;
  end

  always_comb begin
    cpu_do_d = cpu_do_q;
    toggle_d = toggle_q;
    if (rd) begin
      if (state_q == StId) begin
        cpu_do_d = cpu_addr[0] ? DEV_ID : MFR_ID;
      end else if (busy_now) begin
        toggle_d = ~toggle_q;
        cpu_do_d = {dq7, ~toggle_q, 6'b0};
      end else begin
        cpu_do_d = 8'h00;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= StRead;
      data_q      <= 8'h00;
      prog_addr_q <= '0;
      cpu_do_q    <= 8'h00;
      toggle_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      prog_addr_q <= prog_addr_d;
      cpu_do_q    <= cpu_do_d;
      toggle_q    <= toggle_d;
      busy_q      <= is_busy_state(state_d);
    end
  end

  mbc6_flash_mem_if #(
    .ADDR_W   (ADDR_W),
    .SECTOR_W (SECTOR_W)
  ) u_mem_if (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .start_rd    (start_rd),
    .start_wr    (start_wr),
    .start_erase (start_erase),
    .erase_chip  (erase_chip),
    .start_addr  (start_addr),
    .start_wdata (mem_rdata & data_q),
    .ready       (mem_ready),
    .done        (mem_done),
    .rdata       (mem_rdata),
    .dirty       (mem_dirty),
    .mem         (mem)
  );

  assign cpu_do     = cpu_do_q;
  assign cpu_do_ovr = cpu_rd & ((state_q == StId) | busy_now);
  assign busy       = busy_q;
  assign dirty      = mem_dirty;

endmodule

// File: tb/tb_mbc6_flash_ctrl.sv
// Scoreboard bench for mbc6_flash_ctrl. Stimulus pushes expected memory transactions and
// expected CPU read responses; two monitors pop and compare as the DUT presents them.
// Sectors are shrunk to 4KB so the erase walk stays short.
module tb_mbc6_flash_ctrl;

  localparam int unsigned ADDR_W   = 20;
  localparam int unsigned SECTOR_W = 12;

  logic              clk_sys = 1'b0;
  logic              reset = 1'b1;
  logic              ce_cpu = 1'b1;
  logic              flash_en = 1'b1;
  logic              flash_we = 1'b1;
  logic              cpu_wr = 1'b0;
  logic              cpu_rd = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [7:0]        cpu_di = 8'h00;
  logic [7:0]        cpu_do;
  logic              cpu_do_ovr;
  logic              busy;
  logic              dirty;

  mbc6_flash_ctrl_if #(.ADDR_W(ADDR_W)) mem_bus ();

  mbc6_flash_ctrl #(
    .ADDR_W   (ADDR_W),
    .SECTOR_W (SECTOR_W),
    .MFR_ID   (8'hC2),
    .DEV_ID   (8'h81)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ce_cpu     (ce_cpu),
    .flash_en   (flash_en),
    .flash_we   (flash_we),
    .cpu_wr     (cpu_wr),
    .cpu_rd     (cpu_rd),
    .cpu_addr   (cpu_addr),
    .cpu_di     (cpu_di),
    .cpu_do     (cpu_do),
    .cpu_do_ovr (cpu_do_ovr),
    .busy       (busy),
    .dirty      (dirty),
    .mem        (mem_bus)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
  } mem_txn_t;

  typedef struct {
    logic       ovr;
    logic [7:0] data;
  } rd_exp_t;

  mem_txn_t   exp_mem_q[$];
  rd_exp_t    exp_rd_q[$];
  logic [7:0] mem_model[int];
  int         n_checks = 0;
  int         n_fail = 0;
  int         lat = 0;
  int         wait_cnt = 0;
  logic       tgl = 1'b0;
  logic       rd_pend = 1'b0;
  logic       ovr_s = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: ack after 'lat' wait cycles, one-cycle ack pulse.
  initial begin
    mem_bus.ack   = 1'b0;
    mem_bus.rdata = 8'h00;
    forever begin
      @(posedge clk_sys);
      #1;
      if (mem_bus.ack) begin
        mem_bus.ack = 1'b0;
      end else if (mem_bus.req) begin
        if (wait_cnt < lat) begin
          wait_cnt++;
        end else begin
          wait_cnt    = 0;
          mem_bus.ack = 1'b1;
          if (mem_bus.we) mem_model[int'(mem_bus.addr)] = mem_bus.wdata;
          else mem_bus.rdata = mem_model.exists(int'(mem_bus.addr)) ?
                               mem_model[int'(mem_bus.addr)] : 8'hFF;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Memory monitor: every completing transaction must match the head of the queue.
  always @(negedge clk_sys) begin
    if (mem_bus.req && mem_bus.ack) begin
      if (exp_mem_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL mem_unexpected: got we=%0b addr=%0h wdata=%0h expected none",
                 mem_bus.we, mem_bus.addr, mem_bus.wdata);
      end else begin
        mem_txn_t e;
        e = exp_mem_q.pop_front();
        check("mem_txn", {3'b0, mem_bus.we, mem_bus.addr, mem_bus.we ? mem_bus.wdata : 8'h00},
              {3'b0, e.we, e.addr, e.we ? e.wdata : 8'h00});
      end
    end
  end

  // Read monitor: ovr sampled while cpu_rd is high, cpu_do one cycle later.
  always @(negedge clk_sys) begin
    if (rd_pend) begin
      rd_pend = 1'b0;
      if (exp_rd_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected: got ovr=%0b do=%0h expected none", ovr_s, cpu_do);
      end else begin
        rd_exp_t r;
        r = exp_rd_q.pop_front();
        check("rd_ovr", {31'b0, ovr_s}, {31'b0, r.ovr});
        check("rd_data", {24'b0, cpu_do}, {24'b0, r.data});
      end
    end
    if (ce_cpu && cpu_rd) begin
      ovr_s   = cpu_do_ovr;
      rd_pend = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    cpu_addr = a;
    cpu_di   = d;
    cpu_wr   = 1'b1;
    tick();
    cpu_wr   = 1'b0;
  endtask

  task automatic cpu_read(input logic [ADDR_W-1:0] a, input logic ovr, input logic [7:0] d);
    rd_exp_t r;
    r.ovr  = ovr;
    r.data = d;
    exp_rd_q.push_back(r);
    cpu_addr = a;
    cpu_rd   = 1'b1;
    tick();
    cpu_rd   = 1'b0;
    tick();
  endtask

  // Busy status byte as the bench expects it: DQ7 given, DQ6 flips on every busy read.
  task automatic busy_read(input logic dq7);
    tgl = ~tgl;
    cpu_read(20'h00000, 1'b1, {dq7, tgl, 6'b0});
  endtask

  task automatic push_mem(input logic we, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    mem_txn_t e;
    e.we    = we;
    e.addr  = a;
    e.wdata = d;
    exp_mem_q.push_back(e);
  endtask

  task automatic unlock();
    cpu_write(20'h05555, 8'hAA);
    cpu_write(20'h02AAA, 8'h55);
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int k = 0;
    while (busy && k < max_cycles) begin
      tick();
      k++;
    end
    check(name, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    mem_model[32'h01234] = 8'hF0;
    repeat (3) tick();
    // Reset state
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_dirty", {31'b0, dirty}, 32'd0);
    check("rst_do", {24'b0, cpu_do}, 32'd0);
    check("rst_req", {31'b0, mem_bus.req}, 32'd0);
    reset = 1'b0;
    tick();

    // ID mode
    unlock();
    cpu_write(20'h05555, 8'h90);
    cpu_read(20'h00000, 1'b1, 8'hC2);
    cpu_read(20'h00001, 1'b1, 8'h81);
    cpu_write(20'h00000, 8'h12);      // ignored in ID mode
    cpu_read(20'h40001, 1'b1, 8'h81);
    cpu_write(20'h00000, 8'hF0);
    cpu_read(20'h00000, 1'b0, 8'h00);

    // Bad second unlock byte
    cpu_write(20'h05555, 8'hAA);
    cpu_write(20'h02AAA, 8'h54);
    cpu_write(20'h05555, 8'h90);
    cpu_read(20'h00001, 1'b0, 8'h00);

    // Write-protected: program refused, ID still reachable
    flash_we = 1'b0;
    unlock();
    cpu_write(20'h05555, 8'hA0);
    cpu_write(20'h01234, 8'h3C);
    repeat (4) tick();
    check("we0_busy", {31'b0, busy}, 32'd0);
    check("we0_dirty", {31'b0, dirty}, 32'd0);
    cpu_read(20'h01234, 1'b0, 8'h00);
    unlock();
    cpu_write(20'h05555, 8'h90);
    cpu_read(20'h00001, 1'b1, 8'h81);
    cpu_write(20'h00000, 8'hF0);
    flash_we = 1'b1;

    // Sector erase of 0x23xxx
    lat = 0;
    for (int i = 0; i < (1 << SECTOR_W); i++) push_mem(1'b1, 20'h23000 + i, 8'hFF);
    unlock();
    cpu_write(20'h05555, 8'h80);
    unlock();
    cpu_write(20'h23456, 8'h30);
    check("er_busy", {31'b0, busy}, 32'd1);
    busy_read(1'b0);
    cpu_write(20'h05555, 8'hF0);      // ignored while busy
    busy_read(1'b0);
    wait_idle("er_done", 20000);
    tick();
    check("er_dirty", {31'b0, dirty}, 32'd1);
    check("er_drained", exp_mem_q.size(), 32'd0);
    cpu_read(20'h23000, 1'b0, 8'h00);

    // Program 3C over F0 -> writes 30
    lat = 6;
    push_mem(1'b0, 20'h01234, 8'h00);
    push_mem(1'b1, 20'h01234, 8'h30);
    unlock();
    cpu_write(20'h05555, 8'hA0);
    cpu_write(20'h01234, 8'h3C);
    check("pg_busy", {31'b0, busy}, 32'd1);
    busy_read(1'b1);
    busy_read(1'b1);
    wait_idle("pg_done", 200);
    tick();
    check("pg_drained", exp_mem_q.size(), 32'd0);
    cpu_read(20'h01234, 1'b0, 8'h00);

    // flash_en low drops ID mode
    unlock();
    cpu_write(20'h05555, 8'h90);
    cpu_read(20'h00000, 1'b1, 8'hC2);
    flash_en = 1'b0;
    tick();
    flash_en = 1'b1;
    cpu_read(20'h00000, 1'b0, 8'h00);

    // Chip erase, reset once it reaches 0x00100
    lat = 0;
    for (int i = 0; i <= 32'h100; i++) push_mem(1'b1, i[ADDR_W-1:0], 8'hFF);
    unlock();
    cpu_write(20'h05555, 8'h80);
    unlock();
    cpu_write(20'h05555, 8'h10);
    begin
      int k = 0;
      do begin
        @(negedge clk_sys);
        k++;
      end while (!(mem_bus.req && mem_bus.addr == 20'h00100) && k < 2000);
      check("chip_reach_100", {31'b0, mem_bus.addr == 20'h00100}, 32'd1);
    end
    reset = 1'b1;
    tick();
    check("rst_mid_req", {31'b0, mem_bus.req}, 32'd0);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_dirty", {31'b0, dirty}, 32'd0);
    check("rst_mid_do", {24'b0, cpu_do}, 32'd0);
    check("rst_mid_addr", {12'b0, mem_bus.addr}, 32'd0);
    check("rst_mid_we", {31'b0, mem_bus.we}, 32'd0);
    check("rst_mid_wdata", {24'b0, mem_bus.wdata}, 32'd0);
    reset = 1'b0;
    tgl   = 1'b0;
    repeat (4) tick();
    check("rst_mid_idle_req", {31'b0, mem_bus.req}, 32'd0);
    cpu_read(20'h00000, 1'b0, 8'h00);
    repeat (2) tick();
    check("final_drained", exp_mem_q.size() + exp_rd_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
